// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with lane steering, misalignment traps and read-latency FSM
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_allow_in,
    input  logic              ls_load,
    input  logic              ls_store,
    input  logic [1:0]        ls_size,
    input  logic              ls_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wen,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    output logic              dm_ce_n,
    output logic              dm_oe_n,
    output logic              dm_we_n,
    output logic              mem_over,
    output logic [31:0]       mem_result,
    output logic              exc_adel,
    output logic              exc_ades
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0] hold_q, hold_d;

    logic        is_half, is_word, misalign, is_mem;
    logic [3:0]  store_wen;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;
    logic [31:0] addr_ext;

    // RAM is word addressed; lane selection is done with byte enables and load extraction
    assign dm_addr  = {addr[ADDR_W-1:2], 2'b00};
    assign addr_ext = 32'(addr);

    // Access classification, store lane steering and load extraction/extension
    always_comb begin
        is_half   = (ls_size == 2'b01);
        is_word   = ls_size[1];
        misalign  = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        is_mem    = ls_load | ls_store;
        store_wen = 4'b1111;
        dm_wdata  = store_data;
        ld_byte   = dm_rdata[{addr[1:0], 3'b000} +: 8];
        ld_half   = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        load_ext  = dm_rdata;
        case (ls_size)
            2'b00: begin
                store_wen = 4'b0001 << addr[1:0];
                dm_wdata  = {4{store_data[7:0]}};
                load_ext  = {{24{ls_signed & ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                store_wen = addr[1] ? 4'b1100 : 4'b0011;
                dm_wdata  = {2{store_data[15:0]}};
                load_ext  = {{16{ls_signed & ld_half[15]}}, ld_half};
            end
            default: begin
                store_wen = 4'b1111;
                dm_wdata  = store_data;
                load_ext  = dm_rdata;
            end
        endcase
    end

    // Next-state, RAM strobes and stage outputs; a flush (mem_valid low) forces IDLE with no strobes
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        hold_d     = hold_q;
        dm_ce_n    = 1'b1;
        dm_oe_n    = 1'b1;
        dm_we_n    = 1'b1;
        dm_wen     = 4'b0000;
        mem_over   = 1'b0;
        mem_result = 32'h0;
        exc_adel   = 1'b0;
        exc_ades   = 1'b0;
        if (!mem_valid) begin
            state_d   = S_IDLE;
            lat_cnt_d = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!is_mem) begin
                        mem_over   = 1'b1;
                        mem_result = addr_ext;
                    end else if (misalign) begin
                        mem_over = 1'b1;
                        exc_adel = ls_load;
                        exc_ades = ~ls_load;
                    end else if (ls_load) begin
                        dm_ce_n = 1'b0;
                        dm_oe_n = 1'b0;
                        if (RD_LAT == 0) begin
                            mem_over   = 1'b1;
                            mem_result = load_ext;
                            hold_d     = load_ext;
                            if (!mem_allow_in) state_d = S_DONE;
                        end else begin
                            state_d   = S_WAIT;
                            lat_cnt_d = 3'(RD_LAT - 1);
                        end
                    end else begin
                        dm_ce_n    = 1'b0;
                        dm_we_n    = 1'b0;
                        dm_wen     = store_wen;
                        mem_over   = 1'b1;
                        mem_result = addr_ext;
                        // Park in DONE so the write is not repeated while WB stalls
                        if (!mem_allow_in) begin
                            state_d = S_DONE;
                            hold_d  = addr_ext;
                        end
                    end
                end
                S_WAIT: begin
                    dm_ce_n = 1'b0;
                    dm_oe_n = 1'b0;
                    if (lat_cnt_q != 3'd0) begin
                        lat_cnt_d = lat_cnt_q - 3'd1;
                    end else begin
                        mem_over   = 1'b1;
                        mem_result = load_ext;
                        hold_d     = load_ext;
                        state_d    = mem_allow_in ? S_IDLE : S_DONE;
                    end
                end
                S_DONE: begin
                    mem_over   = 1'b1;
                    mem_result = hold_q;
                    if (mem_allow_in) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Outputs show their reset values for the whole time reset is held
        if (!resetn) begin
            dm_ce_n    = 1'b1;
            dm_oe_n    = 1'b1;
            dm_we_n    = 1'b1;
            dm_wen     = 4'b0000;
            mem_over   = 1'b0;
            mem_result = 32'h0;
            exc_adel   = 1'b0;
            exc_ades   = 1'b0;
        end
    end

    // State, latency counter and held load result
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            lat_cnt_q <= 3'd0;
            hold_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            hold_q    <= hold_d;
        end
    end

endmodule
